// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 T-state sequencer: ring width, T-state bit
// positions and the control FSM encoding.
package sap_pkg;

    localparam int NUM_T_DEF = 6;

    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_STEP_IDLE = 2'd1,
        ST_STEP_PEND = 2'd2,
        ST_HALT      = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/tstate_sequencer_btn_sync.sv
// Push-button front end: SYNC_DEPTH-stage synchronizer followed by a rising-edge
// detector that yields a single-cycle pulse per press.
module btn_sync #(
    parameter int SYNC_DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], async_i};
            prev_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign rise_o = sync_q[SYNC_DEPTH-1] & ~prev_q;

endmodule

// File: rtl/tstate_sequencer.sv
// SAP-1 T-state sequencer: gates clocken's enables into cpu_en/cpu_en2 and
// drives the one-hot T-state ring, with free-run, single-step and HLT stop.
module tstate_sequencer
    import sap_pkg::*;
#(
    parameter int NUM_T      = NUM_T_DEF,
    parameter int SYNC_DEPTH = 2
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             clken,
    input  logic             clken2,
    input  logic             run_mode,
    input  logic             step_btn,
    input  logic             hlt,
    input  logic             ring_clr,
    output logic [NUM_T-1:0] tstate,
    output logic             cpu_en,
    output logic             cpu_en2,
    output logic             halted,
    output logic             step_pend
);

    localparam logic [NUM_T-1:0] RING_T1 = NUM_T'(1) << T1;

    ctrl_state_e      state_q;
    logic             halted_q;
    logic             step_pend_q;
    logic [NUM_T-1:0] ring_q, ring_d;
    logic             en2_arm_q, en2_arm_d;
    logic             step_rise;
    logic             cpu_en_w;

    btn_sync #(
        .SYNC_DEPTH (SYNC_DEPTH)
    ) u_step_sync (
        .clk_i   (sysclk),
        .rst_n_i (rst_n),
        .async_i (step_btn),
        .rise_o  (step_rise)
    );

    // Zero-latency gate so cpu_en keeps clken's exact phase.
    assign cpu_en_w = clken & ~halted_q & rst_n & (run_mode | step_pend_q);
    assign cpu_en   = cpu_en_w;
    assign cpu_en2  = clken2 & en2_arm_q & ~halted_q & rst_n;

    always_comb begin
        ring_d    = ring_q;
        en2_arm_d = en2_arm_q;
        if (cpu_en_w) begin
            ring_d    = ring_clr ? RING_T1 : {ring_q[NUM_T-2:0], ring_q[NUM_T-1]};
            en2_arm_d = 1'b1;
        end else if (clken2) begin
            en2_arm_d = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            ring_q    <= RING_T1;
            en2_arm_q <= 1'b0;
        end else begin
            ring_q    <= ring_d;
            en2_arm_q <= en2_arm_d;
        end
    end

    // Control FSM; a step edge that lands with cpu_en is consumed, never re-armed.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q     <= run_mode ? ST_RUN : ST_STEP_IDLE;
            halted_q    <= 1'b0;
            step_pend_q <= 1'b0;
        end else if (cpu_en_w && hlt) begin
            state_q     <= ST_HALT;
            halted_q    <= 1'b1;
            step_pend_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!run_mode) begin
                        state_q     <= step_rise ? ST_STEP_PEND : ST_STEP_IDLE;
                        step_pend_q <= step_rise;
                    end
                end
                ST_STEP_IDLE: begin
                    if (run_mode) begin
                        state_q <= ST_RUN;
                    end else if (step_rise) begin
                        state_q     <= ST_STEP_PEND;
                        step_pend_q <= 1'b1;
                    end
                end
                ST_STEP_PEND: begin
                    if (run_mode) begin
                        state_q     <= ST_RUN;
                        step_pend_q <= 1'b0;
                    end else if (cpu_en_w) begin
                        state_q     <= ST_STEP_IDLE;
                        step_pend_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

    assign tstate    = ring_q;
    assign halted    = halted_q;
    assign step_pend = step_pend_q;

endmodule
